// File: rtl/register_file_scb_pkg.sv
// Shared definitions for the register file with busy scoreboard:
// default geometry, the register index width and the read-source selector.
package register_file_scb_pkg;

  localparam int unsigned DEF_WORD_SIZE = 16;
  localparam int unsigned DEF_NUM_REGS  = 4;
  localparam int unsigned REG_ADDR_W    = $clog2(DEF_NUM_REGS);

  // Where a read port takes its data from in the current cycle.
  typedef enum logic [1:0] {
    SRC_REG  = 2'd0,
    SRC_WR0  = 2'd1,
    SRC_WR1  = 2'd2,
    SRC_ZERO = 2'd3
  } rd_src_e;

endpackage

// File: rtl/register_file_scb_if.sv
// Decode-stage bus of the register file: two read ports, two write ports,
// destination reservation, flush and scoreboard status.
interface register_file_scb_if
  import register_file_scb_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
  parameter int unsigned ADDR_W    = REG_ADDR_W
);
  logic [ADDR_W-1:0]    readReg1;
  logic [ADDR_W-1:0]    readReg2;
  logic [WORD_SIZE-1:0] readData1;
  logic [WORD_SIZE-1:0] readData2;
  logic                 readBusy1;
  logic                 readBusy2;
  logic                 wrEn0;
  logic [ADDR_W-1:0]    wrReg0;
  logic [WORD_SIZE-1:0] wrData0;
  logic                 wrEn1;
  logic [ADDR_W-1:0]    wrReg1;
  logic [WORD_SIZE-1:0] wrData1;
  logic                 reserveEn;
  logic [ADDR_W-1:0]    reserveReg;
  logic                 flush;
  logic [ADDR_W:0]      busyCount;
  logic                 anyBusy;

  modport master (
    output readReg1, readReg2, wrEn0, wrReg0, wrData0, wrEn1, wrReg1, wrData1,
           reserveEn, reserveReg, flush,
    input  readData1, readData2, readBusy1, readBusy2, busyCount, anyBusy
  );

  modport slave (
    input  readReg1, readReg2, wrEn0, wrReg0, wrData0, wrEn1, wrReg1, wrData1,
           reserveEn, reserveReg, flush,
    output readData1, readData2, readBusy1, readBusy2, busyCount, anyBusy
  );
endinterface

// File: rtl/register_file_scb_scoreboard.sv
// Per-register busy scoreboard: flush, then write-clear, then reserve-set,
// with a registered population count of the resulting busy vector.
module reg_scoreboard #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned ADDR_W   = 2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] readReg1_i,
  input  logic [ADDR_W-1:0] readReg2_i,
  input  logic              wrEn0_i,
  input  logic [ADDR_W-1:0] wrReg0_i,
  input  logic              wrEn1_i,
  input  logic [ADDR_W-1:0] wrReg1_i,
  input  logic              reserveEn_i,
  input  logic [ADDR_W-1:0] reserveReg_i,
  input  logic              flush_i,
  output logic              readBusy1_o,
  output logic              readBusy2_o,
  output logic [ADDR_W:0]   busyCount_o,
  output logic              anyBusy_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]     busyCount_q, busyCount_d;

  // Next busy vector; reserve is applied last so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (flush_i)     busy_d = '0;
    if (wrEn0_i)     busy_d[wrReg0_i] = 1'b0;
    if (wrEn1_i)     busy_d[wrReg1_i] = 1'b0;
    if (reserveEn_i) busy_d[reserveReg_i] = 1'b1;
    if (ZERO_REG)    busy_d[0] = 1'b0;
    busyCount_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      busyCount_d = busyCount_d + (ADDR_W+1)'(busy_d[i]);
  end

  // Busy state and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q      <= '0;
      busyCount_q <= '0;
    end else begin
      busy_q      <= busy_d;
      busyCount_q <= busyCount_d;
    end
  end

  // Operand busy flags; a same-cycle write satisfies the operand when bypassing.
  always_comb begin
    readBusy1_o = busy_q[readReg1_i];
    readBusy2_o = busy_q[readReg2_i];
    if (BYPASS) begin
      if ((wrEn0_i && wrReg0_i == readReg1_i) || (wrEn1_i && wrReg1_i == readReg1_i))
        readBusy1_o = 1'b0;
      if ((wrEn0_i && wrReg0_i == readReg2_i) || (wrEn1_i && wrReg1_i == readReg2_i))
        readBusy2_o = 1'b0;
    end
  end

  assign busyCount_o = busyCount_q;
  assign anyBusy_o   = (busyCount_q != '0);

endmodule

// File: rtl/register_file_scb.sv
// Two-read/two-write register file with optional write bypass, optional
// hardwired zero register and a busy scoreboard for hazard detection.
module register_file_scb
  import register_file_scb_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
  parameter int unsigned NUM_REGS  = DEF_NUM_REGS,
  parameter int unsigned ADDR_W    = $clog2(NUM_REGS),
  parameter bit          BYPASS    = 1'b1,
  parameter bit          ZERO_REG  = 1'b0
) (
  input logic                clk,
  input logic                reset_n,
  register_file_scb_if.slave bus
);

  logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
  logic [WORD_SIZE-1:0] regs_d [NUM_REGS];
  rd_src_e              src1, src2;

  function automatic rd_src_e rd_src(input logic [ADDR_W-1:0] a,
                                     input logic e0, input logic [ADDR_W-1:0] r0,
                                     input logic e1, input logic [ADDR_W-1:0] r1);
    if (ZERO_REG && a == '0)          return SRC_ZERO;
    else if (BYPASS && e1 && r1 == a) return SRC_WR1;
    else if (BYPASS && e0 && r0 == a) return SRC_WR0;
    else                              return SRC_REG;
  endfunction

  // Next register contents; port 1 is applied after port 0 so it wins a collision.
  always_comb begin
    regs_d = regs_q;
    if (bus.wrEn0 && !(ZERO_REG && bus.wrReg0 == '0)) regs_d[bus.wrReg0] = bus.wrData0;
    if (bus.wrEn1 && !(ZERO_REG && bus.wrReg1 == '0)) regs_d[bus.wrReg1] = bus.wrData1;
  end

  // Storage array with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read muxes: zero register, then port-1 and port-0 forwarding, then storage.
  always_comb begin
    src1 = rd_src(bus.readReg1, bus.wrEn0, bus.wrReg0, bus.wrEn1, bus.wrReg1);
    src2 = rd_src(bus.readReg2, bus.wrEn0, bus.wrReg0, bus.wrEn1, bus.wrReg1);
    case (src1)
      SRC_WR1:  bus.readData1 = bus.wrData1;
      SRC_WR0:  bus.readData1 = bus.wrData0;
      SRC_ZERO: bus.readData1 = '0;
      default:  bus.readData1 = regs_q[bus.readReg1];
    endcase
    case (src2)
      SRC_WR1:  bus.readData2 = bus.wrData1;
      SRC_WR0:  bus.readData2 = bus.wrData0;
      SRC_ZERO: bus.readData2 = '0;
      default:  bus.readData2 = regs_q[bus.readReg2];
    endcase
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_scb (
    .clk          (clk),
    .reset_n      (reset_n),
    .readReg1_i   (bus.readReg1),
    .readReg2_i   (bus.readReg2),
    .wrEn0_i      (bus.wrEn0),
    .wrReg0_i     (bus.wrReg0),
    .wrEn1_i      (bus.wrEn1),
    .wrReg1_i     (bus.wrReg1),
    .reserveEn_i  (bus.reserveEn),
    .reserveReg_i (bus.reserveReg),
    .flush_i      (bus.flush),
    .readBusy1_o  (bus.readBusy1),
    .readBusy2_o  (bus.readBusy2),
    .busyCount_o  (bus.busyCount),
    .anyBusy_o    (bus.anyBusy)
  );

endmodule
